inst_mem_resp: RTL and testbench
================================

# inst_mem_resp

Instruction memory responder sitting on the fetch side of the PC register. Each cycle it consumes the PC's chip-enable and word address and returns the addressed instruction one cycle later, with a valid flag. After reset it holds the core in a boot phase while a loader streams the program in through a valid/ready port. It then switches to serving fetches until a reload is requested.

## Interface
- AW, 6, word-address width; matches PC width
- DW, 32, instruction width
- DEPTH, 1<<AW, number of instruction words
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- ce  in  1  fetch enable from PC register
- addr  in  AW  fetch word address
- inst  out  DW  fetched instruction (registered)
- inst_valid  out  1  inst holds a fetched word
- stall  out  1  high while in BOOT; core must not advance
- ld_valid  in  1  loader word offered
- ld_ready  out  1  loader word accepted when high with ld_valid
- ld_addr  in  AW  loader write address
- ld_data  in  DW  loader write data
- ld_last  in  1  marks final loader word
- reload  in  1  single-cycle request to re-enter BOOT
- fetch_cnt  out  32  fetches served since last reset/reload (see Configuration)

## Operation
- FSM states: BOOT, RUN. Reset enters BOOT.
- Reset values: inst=0, inst_valid=0, stall=1, ld_ready=0, fetch_cnt=0, state=BOOT. Memory contents are not reset.
- BOOT behaviour:
  - ld_ready=1 from the first edge after reset release.
  - A handshake (ld_valid&ld_ready) writes mem[ld_addr]=ld_data.
  - A handshake with ld_last=1 moves the FSM to RUN at that edge.
  - ce is ignored: inst=0, inst_valid=0.
  - reload is ignored.
- RUN behaviour:
  - ld_ready=0 and stall=0.
  - ce=1 at edge N: inst=mem[addr] and inst_valid=1 are registered at edge N.
  - ce=0: inst=0 (NOP) and inst_valid=0.
- reload=1 in RUN: the fetch on that same edge is still served. The FSM enters BOOT at that edge, so stall=1 and ld_ready=1 from the next cycle.
- Address arithmetic is modulo DEPTH; addr 63 followed by 0 needs no special handling.
- Loader writes to the same address overwrite; last write wins.
- Write and fetch never coincide, since fetches are only served in RUN and writes only in BOOT. No bypass is needed.

## Timing
- Fetch latency is 1 cycle, full throughput: one instruction per cycle while ce=1.
- stall deasserts the cycle after the ld_last handshake edge.
- The first fetch is served at the first edge with stall=0 and ce=1.
- Asynchronous reset:
  - Asserting rst mid-operation forces all outputs to their reset values immediately, without waiting for a clock.
  - The FSM returns to BOOT.
  - Deassertion is sampled at the next rising edge.
- ld_ready is a registered output, with no combinational path from ld_valid.

## Configuration
- INST_MEM_FETCH_CNT_EN defined:
  - fetch_cnt increments by 1 at every edge where a fetch is served (RUN and ce=1).
  - It wraps at 2^32.
  - It clears to 0 on reset and on the reload edge.
  - The reload-edge fetch is not counted.
- Not defined: fetch_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package inst_mem_pkg holds:
  - AW/DW defaults
  - the state typedef (BOOT, RUN)
  - the NOP constant 32'h0000_0000
- Sub-module inst_mem_array: a DEPTH x DW single-write/single-read synchronous RAM. It has registered read data and no reset on its contents.
- The top level holds the FSM, the output registers, the handshake and the optional counter.

## Test plan
- Reset: hold rst=0 for 3 cycles → inst=0, inst_valid=0, stall=1, ld_ready=0. After release, ld_ready=1 at the next edge.
- Boot then fetch:
  - Stimulus: load addr0..2 = 0x34011100, 0x34020020, 0x3403FF00 with ld_last on the third word.
  - Expected: stall=0 the next cycle.
  - Then ce=1 with addr 0,1,2 → inst shows those values one cycle later, inst_valid=1.
  - fetch_cnt=3 with the macro defined, 0 without.
- Fetch during BOOT: ce=1, addr=0 before any load → inst=0 and inst_valid=0 throughout.
- ce drop in RUN: ce 1,0,1 with addr=1 → inst is 0x34020020, then 0, then 0x34020020 with matching inst_valid.
- Reload:
  - Stimulus: reload=1 together with ce=1, addr=2.
  - Expected: inst=0x3403FF00 on the next cycle, then stall=1 and ld_ready=1.
  - Reload addr2=0xFFFFFFFF with ld_last, then fetch addr2 → 0xFFFFFFFF. fetch_cnt restarts from 0.
- Async reset mid-RUN:
  - Stimulus: drop rst between edges while ce=1.
  - Expected: inst, inst_valid and fetch_cnt go to 0 and stall goes to 1 before the next edge.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared widths, FSM state type and NOP word for the instruction memory responder.
package inst_mem_pkg;
    localparam int INST_AW = 6;
    localparam int INST_DW = 32;
    localparam logic [INST_DW-1:0] NOP = 32'h0000_0000;
    typedef enum logic {BOOT, RUN} state_t;
endpackage

// File: rtl/inst_mem_resp_if.sv
// inst_mem_resp_if: fetch, loader and control signals of the instruction memory responder.
// Ports (slave view): in ce/addr/ld_valid/ld_addr/ld_data/ld_last/reload,
// out inst/inst_valid/stall/ld_ready/fetch_cnt.
interface inst_mem_resp_if
    import inst_mem_pkg::*;
#(
    parameter int AW = INST_AW,
    parameter int DW = INST_DW
);
    logic          ce;
    logic [AW-1:0] addr;
    logic [DW-1:0] inst;
    logic          inst_valid;
    logic          stall;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          reload;
    logic [31:0]   fetch_cnt;
    modport slave (
        input  ce, addr, ld_valid, ld_addr, ld_data, ld_last, reload,
        output inst, inst_valid, stall, ld_ready, fetch_cnt
    );
    modport master (
        output ce, addr, ld_valid, ld_addr, ld_data, ld_last, reload,
        input  inst, inst_valid, stall, ld_ready, fetch_cnt
    );
endinterface

// File: rtl/inst_mem_array.sv
// inst_mem_array: DEPTH x DW single-write/single-read synchronous RAM, registered read, contents not reset.
// Ports: i_clk, i_we/i_waddr/i_wdata write port, i_re/i_raddr read port, o_rdata registered read data.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int AW = INST_AW,
    parameter int DW = INST_DW
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [1<<AW];
    logic [DW-1:0] r_rdata;
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: boot-loaded instruction memory serving 1-cycle fetches, BOOT/RUN FSM with reload.
// Ports: i_clk, i_rst_n (async active-low), bus (inst_mem_resp_if.slave).
// Optional macro INST_MEM_FETCH_CNT_EN builds the served-fetch counter; otherwise fetch_cnt is 0.
module inst_mem_resp
    import inst_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    inst_mem_resp_if.slave    bus
);
    state_t               r_state;
    logic                 r_stall;
    logic                 r_ld_ready;
    logic                 r_inst_valid;
    logic                 w_ld_hs;
    logic                 w_fetch;
    logic [INST_DW-1:0]   w_rdata;
    assign w_ld_hs = (r_state == BOOT) && bus.ld_valid && r_ld_ready;
    assign w_fetch = (r_state == RUN) && bus.ce;
    inst_mem_array #(.AW(INST_AW), .DW(INST_DW)) u_array (
        .i_clk   (i_clk),
        .i_we    (w_ld_hs),
        .i_waddr (bus.ld_addr),
        .i_wdata (bus.ld_data),
        .i_re    (w_fetch),
        .i_raddr (bus.addr),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= BOOT;
            r_stall      <= 1'b1;
            r_ld_ready   <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= w_fetch;
            if (r_state == BOOT) begin
                r_state    <= (w_ld_hs && bus.ld_last) ? RUN : BOOT;
                r_stall    <= !(w_ld_hs && bus.ld_last);
                r_ld_ready <= !(w_ld_hs && bus.ld_last);
            end else if (bus.reload) begin
                r_state    <= BOOT;
                r_stall    <= 1'b1;
                r_ld_ready <= 1'b1;
            end
        end
    end
    // RAM read data is unreset, so the async-reset valid flag gates it to NOP.
    assign bus.inst       = r_inst_valid ? w_rdata : NOP;
    assign bus.inst_valid = r_inst_valid;
    assign bus.stall      = r_stall;
    assign bus.ld_ready   = r_ld_ready;
`ifdef INST_MEM_FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_fetch_cnt <= '0;
        else if (r_state == RUN && bus.reload) r_fetch_cnt <= '0;
        else if (w_fetch) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
    assign bus.fetch_cnt = r_fetch_cnt;
`else
    assign bus.fetch_cnt = '0;
`endif
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: scoreboard bench for inst_mem_resp (boot load, fetch, ce drop, reload, async reset).
module tb_inst_mem_resp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [32:0] sb [$];
    inst_mem_resp_if bus();
    inst_mem_resp dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef INST_MEM_FETCH_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic load(input logic [5:0] a, input logic [31:0] d, input logic last);
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_data = d; bus.ld_last = last;
        chk("ld_ready_pre", {31'd0, bus.ld_ready}, 32'd1);
        @(posedge clk); #1;
        chk("boot_inst", bus.inst, 32'd0);
        chk("boot_valid", {31'd0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    endtask

    task automatic step(input logic ce, input logic [5:0] a, input logic rl,
                        input logic [31:0] exp_inst, input logic exp_v);
        logic [32:0] e;
        @(negedge clk);
        bus.ce = ce; bus.addr = a; bus.reload = rl;
        sb.push_back({exp_v, exp_inst});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("inst", bus.inst, e[31:0]);
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, e[32]});
        @(negedge clk);
        bus.reload = 1'b0;
    endtask

    initial begin
        bus.ce = 0; bus.addr = 0; bus.ld_valid = 0; bus.ld_addr = 0;
        bus.ld_data = 0; bus.ld_last = 0; bus.reload = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd1);
        chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("rst_cnt", bus.fetch_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ce = 1'b1; bus.addr = 6'd0;
        @(posedge clk); #1;
        chk("ld_ready_up", {31'd0, bus.ld_ready}, 32'd1);
        chk("boot_stall", {31'd0, bus.stall}, 32'd1);
        step(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        load(6'd0, 32'h3401_1100, 1'b0);
        chk("stall_mid_load", {31'd0, bus.stall}, 32'd1);
        load(6'd1, 32'h3402_0020, 1'b0);
        load(6'd2, 32'h3403_FF00, 1'b1);
        chk("run_stall", {31'd0, bus.stall}, 32'd0);
        chk("run_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        step(1'b1, 6'd0, 1'b0, 32'h3401_1100, 1'b1);
        step(1'b1, 6'd1, 1'b0, 32'h3402_0020, 1'b1);
        step(1'b1, 6'd2, 1'b0, 32'h3403_FF00, 1'b1);
        chk("cnt3", bus.fetch_cnt, cnt_exp(32'd3));
        step(1'b1, 6'd1, 1'b0, 32'h3402_0020, 1'b1);
        step(1'b0, 6'd1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 6'd1, 1'b0, 32'h3402_0020, 1'b1);
        chk("cnt5", bus.fetch_cnt, cnt_exp(32'd5));
        step(1'b1, 6'd2, 1'b1, 32'h3403_FF00, 1'b1);
        chk("reload_stall", {31'd0, bus.stall}, 32'd1);
        chk("reload_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("reload_cnt", bus.fetch_cnt, 32'd0);
        step(1'b1, 6'd2, 1'b0, 32'd0, 1'b0);
        load(6'd2, 32'hFFFF_FFFF, 1'b1);
        chk("reboot_stall", {31'd0, bus.stall}, 32'd0);
        step(1'b1, 6'd2, 1'b0, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 6'd0, 1'b0, 32'h3401_1100, 1'b1);
        chk("cnt_restart", bus.fetch_cnt, cnt_exp(32'd2));
        @(negedge clk);
        bus.ce = 1'b1; bus.addr = 6'd1;
        @(posedge clk); #1;
        chk("pre_arst_valid", {31'd0, bus.inst_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_inst", bus.inst, 32'd0);
        chk("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("arst_stall", {31'd0, bus.stall}, 32'd1);
        chk("arst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("arst_cnt", bus.fetch_cnt, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
